// File: rtl/lane_game_ctrl_if.sv
// Pixel write port toward the vga_adapter: one pixel per cycle while plot is high.
// plot is a valid-only strobe: the adapter always accepts, so there is no ready and
// x/y/colour are meaningful only in cycles where plot=1.
interface lane_game_ctrl_if;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    modport master (output x, output y, output colour, output plot);
    modport slave  (input  x, input  y, input  colour, input  plot);
endinterface

// File: rtl/lane_game_ctrl.sv
// Lane game engine: ping-pong cursor over N lanes, synchronised hit keys with
// saturating score/miss counters, and a full-frame repaint scanner for the VGA path.
module lane_game_ctrl #(
    parameter int LANES       = 4,
    parameter int LANE_W      = 40,
    parameter int LANE_H      = 60,
    parameter int TICK_CYCLES = 50000000,
    parameter int SCORE_W     = 8
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic [LANES-1:0]   target_en,
    input  logic [LANES-1:0]   hit_n,
    lane_game_ctrl_if.master   vga,
    output logic [2:0]         active_lane,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] miss,
    output logic               busy,
    output logic               dbg_state_o
);

    localparam int TICK_W = $clog2(TICK_CYCLES);
    localparam int COL_W  = (LANE_W > 1) ? $clog2(LANE_W) : 1;
    localparam int ROW_W  = (LANE_H > 1) ? $clog2(LANE_H) : 1;

    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_CYCLES - 1);
    localparam logic [2:0]        LAST_LANE   = 3'(LANES - 1);
    localparam logic [COL_W-1:0]  LAST_COL    = COL_W'(LANE_W - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW    = ROW_W'(LANE_H - 1);
    localparam logic [7:0]        ROW_REWIND  = 8'(LANE_W - 1);

    typedef enum logic {IDLE, DRAW} state_e;

    // ---------------- tick generator ----------------
    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick;

    assign tick = (tick_cnt_q == '0);

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            tick_cnt_q <= TICK_RELOAD;
        end else if (tick) begin
            tick_cnt_q <= TICK_RELOAD;
        end else begin
            tick_cnt_q <= tick_cnt_q - TICK_W'(1);
        end
    end

    // ---------------- cursor ----------------
    logic [2:0] lane_q;
    logic       dir_up_q;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            lane_q   <= 3'd0;
            dir_up_q <= 1'b1;
        end else if (tick) begin
            if (dir_up_q) begin
                if (lane_q == LAST_LANE) begin
                    lane_q   <= LAST_LANE - 3'd1;
                    dir_up_q <= 1'b0;
                end else begin
                    lane_q <= lane_q + 3'd1;
                end
            end else begin
                if (lane_q == 3'd0) begin
                    lane_q   <= 3'd1;
                    dir_up_q <= 1'b1;
                end else begin
                    lane_q <= lane_q - 3'd1;
                end
            end
        end
    end

    // ---------------- hit key synchronisers ----------------
    // sync3 holds the previous synchronised value, so a press is a 1 -> 0 step.
    logic [LANES-1:0] sync1_q, sync2_q, sync3_q;
    logic [LANES-1:0] press;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            sync1_q <= '1;
            sync2_q <= '1;
            sync3_q <= '1;
        end else begin
            sync1_q <= hit_n;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign press = sync3_q & ~sync2_q;

    // ---------------- scoring ----------------
    logic [LANES-1:0]   hit_mask;
    logic               got_hit, got_miss;
    logic [SCORE_W-1:0] score_q, score_d, miss_q, miss_d;

    always_comb begin
        hit_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            hit_mask[i] = press[i] & target_en[i] & (lane_q == 3'(i));
        end
    end

    assign got_hit  = |hit_mask;
    assign got_miss = |(press & ~hit_mask);
    assign score_d  = (got_hit && (score_q != '1)) ? score_q + SCORE_W'(1) : score_q;
    assign miss_d   = (got_miss && (miss_q != '1)) ? miss_q + SCORE_W'(1) : miss_q;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            score_q <= '0;
            miss_q  <= '0;
        end else begin
            score_q <= score_d;
            miss_q  <= miss_d;
        end
    end

    // ---------------- repaint requests ----------------
    logic [LANES-1:0] tgt_q;
    logic             repaint_req;

    always_ff @(posedge CLOCK_50) begin
        tgt_q <= target_en;
    end

    assign repaint_req = tick | (tgt_q != target_en) | (score_d != score_q);

    // ---------------- repaint scanner ----------------
    state_e           state_q;
    logic             pending_q;
    logic [2:0]       scan_lane_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [7:0]       x_q;
    logic [6:0]       y_q;
    logic [2:0]       colour_q;
    logic             plot_q;
    logic             last_px, lane_done;
    logic [2:0]       nxt_lane;
    logic             nxt_armed;
    logic [2:0]       nxt_colour;

    always_comb begin
        lane_done = (col_q == LAST_COL) && (row_q == LAST_ROW);
        last_px   = lane_done && (scan_lane_q == LAST_LANE);
        if (state_q == IDLE) begin
            nxt_lane = 3'd0;
        end else if (lane_done) begin
            nxt_lane = scan_lane_q + 3'd1;
        end else begin
            nxt_lane = scan_lane_q;
        end
        nxt_armed = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (nxt_lane == 3'(i)) nxt_armed = target_en[i];
        end
        // Red marks the cursor lane, green an armed target; both gives yellow.
        nxt_colour = {nxt_lane == lane_q, nxt_armed, 1'b0};
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q     <= IDLE;
            pending_q   <= 1'b1;
            scan_lane_q <= 3'd0;
            col_q       <= '0;
            row_q       <= '0;
            x_q         <= 8'd0;
            y_q         <= 7'd0;
            colour_q    <= 3'd0;
            plot_q      <= 1'b0;
        end else begin
            pending_q <= pending_q | repaint_req;
            case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        // A request landing on the start cycle keeps pending set.
                        pending_q   <= repaint_req;
                        state_q     <= DRAW;
                        scan_lane_q <= 3'd0;
                        col_q       <= '0;
                        row_q       <= '0;
                        x_q         <= 8'd0;
                        y_q         <= 7'd0;
                        colour_q    <= nxt_colour;
                        plot_q      <= 1'b1;
                    end
                end
                DRAW: begin
                    if (last_px) begin
                        state_q  <= IDLE;
                        plot_q   <= 1'b0;
                        colour_q <= 3'd0;
                    end else begin
                        colour_q <= nxt_colour;
                        if (col_q != LAST_COL) begin
                            col_q <= col_q + COL_W'(1);
                            x_q   <= x_q + 8'd1;
                        end else if (row_q != LAST_ROW) begin
                            col_q <= '0;
                            row_q <= row_q + ROW_W'(1);
                            x_q   <= x_q - ROW_REWIND;
                            y_q   <= y_q + 7'd1;
                        end else begin
                            col_q       <= '0;
                            row_q       <= '0;
                            scan_lane_q <= scan_lane_q + 3'd1;
                            x_q         <= x_q + 8'd1;
                            y_q         <= 7'd0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign vga.x       = x_q;
    assign vga.y       = y_q;
    assign vga.colour  = colour_q;
    assign vga.plot    = plot_q;
    assign busy        = plot_q;
    assign dbg_state_o = (state_q == DRAW);
    assign active_lane = lane_q;
    assign score       = score_q;
    assign miss        = miss_q;

endmodule

// File: tb/tb_lane_game_ctrl.sv
// Bench for lane_game_ctrl: small geometry and tick period, scenario tasks with
// inline checks against a lane/score model derived from the game rules.
module tb_lane_game_ctrl;
    localparam int LANES = 4;
    localparam int LANE_W = 2;
    localparam int LANE_H = 2;
    localparam int T = 64;
    localparam int SW = 2;
    localparam int SAT = (1 << SW) - 1;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [3:0] target_en = 4'b0000;
    logic [3:0] hit_n = 4'b1111;
    logic [2:0] active_lane;
    logic [SW-1:0] score, miss;
    logic busy, dbg_state;

    lane_game_ctrl_if vga();

    lane_game_ctrl #(
        .LANES(LANES), .LANE_W(LANE_W), .LANE_H(LANE_H),
        .TICK_CYCLES(T), .SCORE_W(SW)
    ) dut (
        .CLOCK_50(clk), .resetn(resetn), .target_en(target_en), .hit_n(hit_n),
        .vga(vga), .active_lane(active_lane), .score(score), .miss(miss),
        .busy(busy), .dbg_state_o(dbg_state)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int exp_score = 0;
    int exp_miss = 0;
    logic [17:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // cyc = number of rising edges with reset released; cursor has stepped cyc/T times.
    always @(posedge clk) begin
        if (!resetn) cyc <= 0;
        else cyc <= cyc + 1;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int lane_at(input int c);
        int p;
        p = (c / T) % (2 * (LANES - 1));
        return (p < LANES) ? p : 2 * (LANES - 1) - p;
    endfunction

    // Press on pins at cycle k is judged against the cursor two edges later.
    function automatic void model_press(input int k, input logic [3:0] mask, input logic [3:0] tgt);
        logic [3:0] oh;
        oh = 4'(1 << lane_at(k + 2));
        if (|(mask & tgt & oh)) exp_score = (exp_score < SAT) ? exp_score + 1 : SAT;
        if (|(mask & ~(tgt & oh))) exp_miss = (exp_miss < SAT) ? exp_miss + 1 : SAT;
    endfunction

    // ---------------- drivers ----------------
    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        hit_n = 4'b1111;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        exp_score = 0;
        exp_miss = 0;
    endtask

    task automatic wait_to(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic press_start(input int k, input logic [3:0] mask, input logic [3:0] tgt);
        wait_to(k);
        target_en = tgt;
        hit_n = ~mask;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp += 8;
        if (vga.x !== 8'd0) begin n_bad++; $display("FAIL reset_x: got %0d expected 0", vga.x); end
        if (vga.y !== 7'd0) begin n_bad++; $display("FAIL reset_y: got %0d expected 0", vga.y); end
        if (vga.colour !== 3'd0) begin n_bad++; $display("FAIL reset_colour: got %0d expected 0", vga.colour); end
        if (vga.plot !== 1'b0) begin n_bad++; $display("FAIL reset_plot: got %0d expected 0", vga.plot); end
        if (active_lane !== 3'd0) begin n_bad++; $display("FAIL reset_lane: got %0d expected 0", active_lane); end
        if (score !== '0) begin n_bad++; $display("FAIL reset_score: got %0d expected 0", score); end
        if (miss !== '0) begin n_bad++; $display("FAIL reset_miss: got %0d expected 0", miss); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0d expected 0", busy); end
        resetn = 1'b1;
    endtask

    task automatic test_cursor_sweep();
        int seq [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wait_to(i * T);
            n_cmp++;
            if (active_lane !== 3'(seq[i])) begin
                n_bad++; $display("FAIL sweep_step%0d: got %0d expected %0d", i, active_lane, seq[i]);
            end
            wait_to(i * T + T - 1);
            n_cmp++;
            if (active_lane !== 3'(seq[i])) begin
                n_bad++; $display("FAIL sweep_hold%0d: got %0d expected %0d", i, active_lane, seq[i]);
            end
        end
    endtask

    task automatic test_frame_geometry();
        logic [3:0] tgt;
        int n_plot;
        logic [17:0] e;
        tgt = 4'b0100;
        target_en = tgt;
        exp_q.delete();
        for (int ln = 0; ln < LANES; ln++)
            for (int yy = 0; yy < LANE_H; yy++)
                for (int xx = 0; xx < LANE_W; xx++)
                    exp_q.push_back({8'(ln * LANE_W + xx), 7'(yy), (ln == 0), tgt[ln], 1'b0});
        do_reset();
        n_cmp++;
        if (vga.plot !== 1'b0) begin n_bad++; $display("FAIL frame_idle0: got %0d expected 0", vga.plot); end
        n_plot = 0;
        for (int k = 1; k <= 24; k++) begin
            wait_to(k);
            if (vga.plot === 1'b1) begin
                n_plot++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if ({vga.x, vga.y, vga.colour} !== e) begin
                        n_bad++;
                        $display("FAIL frame_pixel%0d: got x=%0d y=%0d c=%b expected x=%0d y=%0d c=%b",
                                 n_plot, vga.x, vga.y, vga.colour, e[17:10], e[9:3], e[2:0]);
                    end
                    n_cmp++;
                    if (busy !== 1'b1) begin n_bad++; $display("FAIL frame_busy: got %0d expected 1", busy); end
                end
            end
        end
        n_cmp++;
        if (n_plot != LANES * LANE_W * LANE_H) begin
            n_bad++; $display("FAIL frame_length: got %0d expected %0d", n_plot, LANES * LANE_W * LANE_H);
        end
    endtask

    task automatic test_scoring();
        int k;
        target_en = 4'b0100;
        do_reset();
        k = 2 * T + 1;
        press_start(k, 4'b0100, 4'b0100);
        wait_to(k + 2);
        n_cmp += 2;
        if (active_lane !== 3'(lane_at(k + 2))) begin n_bad++; $display("FAIL score_lane: got %0d expected %0d", active_lane, lane_at(k + 2)); end
        if (score !== SW'(exp_score)) begin n_bad++; $display("FAIL score_early: got %0d expected %0d", score, exp_score); end
        model_press(k, 4'b0100, 4'b0100);
        wait_to(k + 3);
        n_cmp++;
        if (score !== SW'(exp_score)) begin n_bad++; $display("FAIL score_hit: got %0d expected %0d", score, exp_score); end
        hit_n = 4'b1111;
        press_start(k + 6, 4'b0010, 4'b0100);
        model_press(k + 6, 4'b0010, 4'b0100);
        wait_to(k + 9);
        n_cmp += 2;
        if (miss !== SW'(exp_miss)) begin n_bad++; $display("FAIL score_wrong_lane_miss: got %0d expected %0d", miss, exp_miss); end
        if (score !== SW'(exp_score)) begin n_bad++; $display("FAIL score_wrong_lane_score: got %0d expected %0d", score, exp_score); end
        hit_n = 4'b1111;
        press_start(k + 12, 4'b0100, 4'b0000);
        model_press(k + 12, 4'b0100, 4'b0000);
        wait_to(k + 15);
        n_cmp += 2;
        if (miss !== SW'(exp_miss)) begin n_bad++; $display("FAIL score_unarmed_miss: got %0d expected %0d", miss, exp_miss); end
        if (score !== SW'(exp_score)) begin n_bad++; $display("FAIL score_unarmed_score: got %0d expected %0d", score, exp_score); end
        hit_n = 4'b1111;
    endtask

    task automatic test_simultaneous();
        target_en = 4'b0011;
        do_reset();
        press_start(4, 4'b0011, 4'b0011);
        wait_to(6);
        n_cmp++;
        if ({score, miss} !== '0) begin n_bad++; $display("FAIL simul_early: got %0d/%0d expected 0/0", score, miss); end
        model_press(4, 4'b0011, 4'b0011);
        wait_to(7);
        n_cmp += 2;
        if (score !== SW'(exp_score)) begin n_bad++; $display("FAIL simul_score: got %0d expected %0d", score, exp_score); end
        if (miss !== SW'(exp_miss)) begin n_bad++; $display("FAIL simul_miss: got %0d expected %0d", miss, exp_miss); end
        hit_n = 4'b1111;
    endtask

    task automatic test_saturation();
        int k;
        logic [3:0] m;
        target_en = 4'b1111;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            k = 4 + 6 * i;
            m = 4'(1 << lane_at(k + 2));
            press_start(k, m, 4'b1111);
            model_press(k, m, 4'b1111);
            wait_to(k + 3);
            n_cmp++;
            if (score !== SW'(exp_score)) begin n_bad++; $display("FAIL sat_hit%0d: got %0d expected %0d", i, score, exp_score); end
            hit_n = 4'b1111;
        end
        wait_to(50);
        n_cmp++;
        if (score !== SW'(SAT)) begin n_bad++; $display("FAIL sat_hold: got %0d expected %0d", score, SAT); end
    endtask

    task automatic test_random();
        int k;
        logic [3:0] m, t;
        target_en = 4'($urandom_range(0, 15));
        do_reset();
        k = 2;
        for (int i = 0; i < 40; i++) begin
            k = k + $urandom_range(4, 40);
            m = 4'($urandom_range(1, 15));
            t = 4'($urandom_range(0, 15));
            press_start(k, m, t);
            model_press(k, m, t);
            wait_to(k + 3);
            n_cmp += 3;
            if (score !== SW'(exp_score)) begin n_bad++; $display("FAIL rand_score%0d: got %0d expected %0d", i, score, exp_score); end
            if (miss !== SW'(exp_miss)) begin n_bad++; $display("FAIL rand_miss%0d: got %0d expected %0d", i, miss, exp_miss); end
            if (active_lane !== 3'(lane_at(k + 3))) begin n_bad++; $display("FAIL rand_lane%0d: got %0d expected %0d", i, active_lane, lane_at(k + 3)); end
            hit_n = 4'b1111;
        end
    endtask

    task automatic test_coalesce();
        logic rec [61];
        int idx, run1, gap, run2, total;
        target_en = 4'b0000;
        do_reset();
        for (int k = 1; k <= 60; k++) begin
            wait_to(k);
            rec[k] = vga.plot;
            if (k == 5) target_en = 4'b0001;
        end
        idx = 1; run1 = 0; gap = 0; run2 = 0; total = 0;
        while (idx <= 60 && rec[idx] === 1'b1) begin run1++; idx++; end
        while (idx <= 60 && rec[idx] === 1'b0) begin gap++; idx++; if (gap > 2) break; end
        while (idx <= 60 && rec[idx] === 1'b1) begin run2++; idx++; end
        for (int k = 1; k <= 60; k++) if (rec[k] === 1'b1) total++;
        n_cmp += 4;
        if (run1 != 16) begin n_bad++; $display("FAIL coal_frame1: got %0d expected 16", run1); end
        if (gap != 1) begin n_bad++; $display("FAIL coal_gap: got %0d expected 1", gap); end
        if (run2 != 16) begin n_bad++; $display("FAIL coal_frame2: got %0d expected 16", run2); end
        if (total != 32) begin n_bad++; $display("FAIL coal_total: got %0d expected 32", total); end
    endtask

    task automatic test_reset_mid_frame();
        target_en = 4'b0001;
        do_reset();
        press_start(4, 4'b0001, 4'b0001);
        model_press(4, 4'b0001, 4'b0001);
        wait_to(7);
        hit_n = 4'b1111;
        wait_to(T + 5);
        n_cmp += 3;
        if (vga.plot !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_plot: got %0d expected 1", vga.plot); end
        if (active_lane !== 3'(lane_at(T + 5))) begin n_bad++; $display("FAIL midrst_pre_lane: got %0d expected %0d", active_lane, lane_at(T + 5)); end
        if (score !== SW'(exp_score)) begin n_bad++; $display("FAIL midrst_pre_score: got %0d expected %0d", score, exp_score); end
        resetn = 1'b0;
        @(negedge clk);
        n_cmp += 4;
        if (vga.plot !== 1'b0) begin n_bad++; $display("FAIL midrst_plot: got %0d expected 0", vga.plot); end
        if (score !== '0) begin n_bad++; $display("FAIL midrst_score: got %0d expected 0", score); end
        if (active_lane !== 3'd0) begin n_bad++; $display("FAIL midrst_lane: got %0d expected 0", active_lane); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %0d expected 0", busy); end
        resetn = 1'b1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_cursor_sweep();
        test_frame_geometry();
        test_scoring();
        test_simultaneous();
        test_saturation();
        test_random();
        test_coalesce();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
